// File: rtl/trng_ctrl_if.sv
// Valid/ready word channel between the TRNG controller and the register block.
//   data  : 32-bit random word (held stable while valid is high)
//   valid : data holds an unread word
//   ready : consumer accepts data on a clock edge where valid is also high
// The master modport belongs to the controller and the slave modport to the consumer.
interface trng_ctrl_if;
    logic [31:0] data;
    logic        valid;
    logic        ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/trng_ctrl.sv
// Controller for the ring-oscillator TRNG macro. It sequences the macro reset
// and holds the macro trim settings. It synchronises and samples the raw bit,
// removes bias with von Neumann pairing, and runs a repetition-count health
// test. It packs the accepted bits into 32-bit words.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   en_i                    enable; low returns to IDLE (FAIL is only left via clear_fail_i)
//   clear_fail_i            leaves the FAIL state
//   trim_fast_i/trim_slow_i trim settings, captured only while IDLE
//   trng_i                  raw macro bit, asynchronous to clk_i
//   ring_rst_o              macro reset, high in IDLE and FAIL
//   trim_fast_o/trim_slow_o latched trim driven to the macro
//   bus                     word channel (data/valid out, ready in)
//   health_fail_o           high while in FAIL
//   state_o                 IDLE=0 WARMUP=1 COLLECT=2 HOLD=3 FAIL=4
module trng_ctrl #(
    parameter int TRIM_BITS     = 26,
    parameter int WARMUP_CYCLES = 1024,
    parameter int SAMPLE_DIV    = 16,
    parameter int RCT_CUTOFF    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 clear_fail_i,
    input  logic [TRIM_BITS-1:0] trim_fast_i,
    input  logic [TRIM_BITS-1:0] trim_slow_i,
    input  logic                 trng_i,
    output logic                 ring_rst_o,
    output logic [TRIM_BITS-1:0] trim_fast_o,
    output logic [TRIM_BITS-1:0] trim_slow_o,
    trng_ctrl_if.master          bus,
    output logic                 health_fail_o,
    output logic [2:0]           state_o
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WARMUP  = 3'd1;
    localparam logic [2:0] ST_COLLECT = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_FAIL    = 3'd4;

    localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
    localparam int DIV_W  = $clog2(SAMPLE_DIV + 1);
    localparam int RUN_W  = $clog2(RCT_CUTOFF + 1);

    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [RUN_W-1:0]  RUN_CUT   = RUN_W'(RCT_CUTOFF);

    logic [2:0]        state;
    logic              sync1;
    logic              sync2;
    logic [WARM_W-1:0] warm_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [RUN_W-1:0]  run_cnt;
    logic              last_sample;
    logic              phase;
    logic              first_sample;
    logic [31:0]       word;
    logic [5:0]        bit_cnt;
    logic [31:0]       out_data;
    logic              out_valid;

    logic              sample;
    logic              sample_tick;
    logic [RUN_W-1:0]  run_next;
    logic              rct_hit;
    logic              pair_ok;
    logic [31:0]       word_next;
    logic              word_done;

    assign sample        = sync2;
    assign ring_rst_o    = (state == ST_IDLE) || (state == ST_FAIL);
    assign health_fail_o = (state == ST_FAIL);
    assign state_o       = state;
    assign bus.data      = out_data;
    assign bus.valid     = out_valid;

    always_comb begin
        sample_tick = (state == ST_COLLECT) && (div_cnt == DIV_LAST);
        // A cleared run counter means no sample has been seen since warm-up,
        // so the next sample starts a fresh run.
        if (run_cnt == '0 || sample != last_sample) begin
            run_next = RUN_W'(1);
        end else begin
            run_next = run_cnt + RUN_W'(1);
        end
        rct_hit   = sample_tick && (run_next == RUN_CUT);
        // The second sample of a pair completes it. 10 yields 1 and 01 yields 0,
        // so the accepted bit is always the first sample of the pair.
        pair_ok   = sample_tick && phase && (first_sample != sample);
        word_next = {word[30:0], first_sample};
        word_done = pair_ok && (bit_cnt == 6'd31);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            trim_fast_o  <= '0;
            trim_slow_o  <= '0;
            warm_cnt     <= '0;
            div_cnt      <= '0;
            run_cnt      <= '0;
            last_sample  <= 1'b0;
            phase        <= 1'b0;
            first_sample <= 1'b0;
            word         <= '0;
            bit_cnt      <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
        end else begin
            sync1 <= trng_i;
            sync2 <= sync1;

            case (state)
                ST_IDLE: begin
                    trim_fast_o <= trim_fast_i;
                    trim_slow_o <= trim_slow_i;
                    if (en_i) begin
                        state    <= ST_WARMUP;
                        warm_cnt <= '0;
                    end
                end

                ST_WARMUP: begin
                    if (!en_i) begin
                        state <= ST_IDLE;
                    end else if (warm_cnt == WARM_LAST) begin
                        state   <= ST_COLLECT;
                        div_cnt <= '0;
                        run_cnt <= '0;
                        bit_cnt <= '0;
                        phase   <= 1'b0;
                    end else begin
                        warm_cnt <= warm_cnt + WARM_W'(1);
                    end
                end

                ST_COLLECT: begin
                    if (!en_i) begin
                        state   <= ST_IDLE;
                        bit_cnt <= '0;
                        phase   <= 1'b0;
                    end else begin
                        div_cnt <= sample_tick ? '0 : div_cnt + DIV_W'(1);
                        if (sample_tick) begin
                            last_sample <= sample;
                            run_cnt     <= run_next;
                            if (rct_hit) begin
                                // A health failure takes priority over a word that
                                // would complete on the same sample.
                                state   <= ST_FAIL;
                                bit_cnt <= '0;
                                phase   <= 1'b0;
                            end else begin
                                phase <= ~phase;
                                if (!phase) begin
                                    first_sample <= sample;
                                end
                                if (pair_ok) begin
                                    word    <= word_next;
                                    bit_cnt <= bit_cnt + 6'd1;
                                end
                                if (word_done) begin
                                    state     <= ST_HOLD;
                                    out_data  <= word_next;
                                    out_valid <= 1'b1;
                                end
                            end
                        end
                    end
                end

                ST_HOLD: begin
                    if (!en_i) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        bit_cnt   <= '0;
                        phase     <= 1'b0;
                    end else if (out_valid && bus.ready) begin
                        state     <= ST_COLLECT;
                        out_valid <= 1'b0;
                        bit_cnt   <= '0;
                        phase     <= 1'b0;
                    end
                end

                ST_FAIL: begin
                    if (clear_fail_i) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trng_ctrl.sv
// Bench for trng_ctrl with small parameters: WARMUP_CYCLES=8, SAMPLE_DIV=2, RCT_CUTOFF=32.
// Cycle numbering counts from the enabling edge E0. The state is WARMUP after E0
// and COLLECT after E8. Raw sample k is taken at edge E(10+2k). Because of the
// 2-flop synchroniser, sample k sees the trng value present at edge E(8+2k).
module tb_trng_ctrl;
    localparam int TB = 26;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          clear_fail;
    logic [TB-1:0] tf_i;
    logic [TB-1:0] ts_i;
    logic          trng;
    logic          ring_rst;
    logic [TB-1:0] tf_o;
    logic [TB-1:0] ts_o;
    logic          health;
    logic [2:0]    st;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            mode = 0;
    int            stable = 0;
    logic [31:0]   exp_q[$];

    trng_ctrl_if bus ();

    always #5 clk = ~clk;

    trng_ctrl #(
        .TRIM_BITS(TB), .WARMUP_CYCLES(8), .SAMPLE_DIV(2), .RCT_CUTOFF(32)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clear_fail_i(clear_fail),
        .trim_fast_i(tf_i), .trim_slow_i(ts_i), .trng_i(trng),
        .ring_rst_o(ring_rst), .trim_fast_o(tf_o), .trim_slow_o(ts_o),
        .bus(bus), .health_fail_o(health), .state_o(st)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Raw bit stream per mode, indexed by edge number.
    // mode 1: samples 1,0,0,1,... -> pairs 10,01 -> bits 1,0,... -> 0xAAAAAAAA
    // mode 2: samples 1,1,0,0,0,1,1,0,... -> 11,00 dropped, 01->0, 10->1 -> 0x55555555
    // mode 3: stuck at 1
    function automatic logic trng_val(input int m, input int c);
        int k;
        if (m == 3) return 1'b1;
        if (c < 8) return 1'b0;
        k = (c - 8) / 2;
        if (m == 1) begin
            case (k % 4)
                0, 3:    return 1'b1;
                default: return 1'b0;
            endcase
        end
        if (m == 2) begin
            case (k % 8)
                0, 1, 5, 6: return 1'b1;
                default:    return 1'b0;
            endcase
        end
        return 1'b0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic advance_to(input int target);
        while (cyc < target) begin
            trng = trng_val(mode, cyc + 1);
            step();
            cyc++;
        end
    endtask

    task automatic start(input int m);
        mode = m;
        en   = 1'b1;
        trng = trng_val(m, 0);
        step();
        cyc  = 0;
    endtask

    // Monitor: pop the expected word at every handshake the DUT is about to take.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.valid === 1'b1 && bus.ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL word_unexpected: got 0x%0h expected none", bus.data);
            end else begin
                check("word", bus.data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; clear_fail = 1'b0; trng = 1'b0;
        tf_i = 26'h1234567; ts_i = 26'h2ABCDEF; bus.ready = 1'b0;
        repeat (3) step();
        check("rst_state", st, 3'd0);
        check("rst_ring_rst", ring_rst, 1'b1);
        check("rst_valid", bus.valid, 1'b0);
        check("rst_health", health, 1'b0);
        check("rst_trim_fast", tf_o, 26'h0);
        check("rst_data", bus.data, 32'h0);

        rst_n = 1'b1;
        step();
        check("idle_trim_fast", tf_o, 26'h1234567);
        check("idle_trim_slow", ts_o, 26'h2ABCDEF);

        // Warm-up timing, first word 0xAAAAAAAA, held with ready low
        exp_q.push_back(32'hAAAAAAAA);
        start(1);
        check("warm_state", st, 3'd1);
        check("warm_ring_rst", ring_rst, 1'b0);
        advance_to(7);
        check("warm_end_state", st, 3'd1);
        advance_to(8);
        check("collect_state", st, 3'd2);
        check("collect_ring_rst", ring_rst, 1'b0);
        advance_to(135);
        check("pre_word_valid", bus.valid, 1'b0);
        advance_to(136);
        check("word1_valid", bus.valid, 1'b1);
        check("word1_state", st, 3'd3);
        check("word1_data", bus.data, 32'hAAAAAAAA);

        for (int i = 0; i < 100; i++) begin
            advance_to(cyc + 1);
            if (bus.valid === 1'b1 && bus.data === 32'hAAAAAAAA && st === 3'd3) stable++;
        end
        check("hold_stable_cycles", stable, 100);

        bus.ready = 1'b1;
        advance_to(cyc + 1);
        bus.ready = 1'b0;
        check("post_hs_valid", bus.valid, 1'b0);
        check("post_hs_state", st, 3'd2);
        check("post_hs_data_kept", bus.data, 32'hAAAAAAAA);

        // Trim frozen outside IDLE, reloads one cycle after returning to IDLE
        tf_i = 26'h0F0F0F0; ts_i = 26'h3C3C3C3;
        advance_to(cyc + 2);
        check("collect_trim_fast", tf_o, 26'h1234567);
        check("collect_trim_slow", ts_o, 26'h2ABCDEF);
        en = 1'b0;
        advance_to(cyc + 1);
        check("dis_state", st, 3'd0);
        check("dis_ring_rst", ring_rst, 1'b1);
        check("dis_trim_same_edge", tf_o, 26'h1234567);
        advance_to(cyc + 1);
        check("idle_trim_fast_new", tf_o, 26'h0F0F0F0);
        check("idle_trim_slow_new", ts_o, 26'h3C3C3C3);

        // Second word with dropped 00/11 pairs, consumer always ready
        bus.ready = 1'b1;
        exp_q.push_back(32'h55555555);
        start(2);
        advance_to(263);
        check("word2_pre_valid", bus.valid, 1'b0);
        advance_to(264);
        check("word2_valid", bus.valid, 1'b1);
        check("word2_state", st, 3'd3);
        advance_to(265);
        check("word2_post_state", st, 3'd2);
        check("word2_post_valid", bus.valid, 1'b0);
        en = 1'b0;
        bus.ready = 1'b0;
        advance_to(cyc + 1);
        check("word2_idle", st, 3'd0);

        // Repetition-count failure on the 32nd identical sample
        start(3);
        advance_to(71);
        check("rct_pre_state", st, 3'd2);
        advance_to(72);
        check("rct_state", st, 3'd4);
        check("rct_health", health, 1'b1);
        check("rct_ring_rst", ring_rst, 1'b1);
        check("rct_valid", bus.valid, 1'b0);
        en = 1'b0;
        advance_to(cyc + 1);
        check("fail_en_low", st, 3'd4);
        en = 1'b1;
        advance_to(cyc + 1);
        check("fail_en_high", st, 3'd4);
        clear_fail = 1'b1;
        advance_to(cyc + 1);
        clear_fail = 1'b0;
        check("clear_state", st, 3'd0);
        check("clear_health", health, 1'b0);
        advance_to(cyc + 1);
        check("clear_rewarm", st, 3'd1);

        // Asynchronous reset in the middle of COLLECT
        en = 1'b0;
        advance_to(cyc + 1);
        start(1);
        advance_to(12);
        check("pre_rst_state", st, 3'd2);
        rst_n = 1'b0;
        #2;
        check("async_rst_state", st, 3'd0);
        check("async_rst_ring_rst", ring_rst, 1'b1);
        check("async_rst_valid", bus.valid, 1'b0);
        en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_state", st, 3'd0);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
